// File: rtl/id_stage.sv
// RV32I/RV64I decode stage: decodes OP-IMM/OP/LUI/AUIPC and resolves RAW hazards.
// Registers a bundle for EX. Define ID_FORWARD_EN to forward from EX/MEM instead of stalling.

module id_opnd #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              i_re,
  input  logic [REG_AW-1:0] i_rs,
  input  logic [XLEN-1:0]   i_rdata,
  input  logic              i_ex_we,
  input  logic              i_ex_is_load,
  input  logic [REG_AW-1:0] i_ex_waddr,
  input  logic [XLEN-1:0]   i_ex_wdata,
  input  logic              i_mem_we,
  input  logic [REG_AW-1:0] i_mem_waddr,
  input  logic [XLEN-1:0]   i_mem_wdata,
  output logic [XLEN-1:0]   o_val,
  output logic              o_stall
);
  logic w_live, w_ex_hit, w_mem_hit;
  assign w_live    = i_re & (i_rs != '0);
  assign w_ex_hit  = w_live & i_ex_we & (i_ex_waddr == i_rs);
  assign w_mem_hit = w_live & i_mem_we & (i_mem_waddr == i_rs);

`ifdef ID_FORWARD_EN
  // EX is younger than MEM, so its value takes priority.
  always_comb begin
    o_val = i_rdata;
    if (!w_live)       o_val = '0;
    else if (w_ex_hit) o_val = i_ex_wdata;
    else if (w_mem_hit) o_val = i_mem_wdata;
  end
  assign o_stall = w_ex_hit & i_ex_is_load;
`else
  logic w_unused;
  assign w_unused = ^{i_ex_is_load, i_ex_wdata, i_mem_wdata};
  assign o_val    = w_live ? i_rdata : '0;
  assign o_stall  = w_ex_hit | w_mem_hit;
`endif
endmodule

module id_stage #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int ALUSEL_W = 3,
  parameter int ALUOP_W  = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_if_valid,
  output logic                o_if_ready,
  input  logic [XLEN-1:0]     i_if_pc,
  input  logic [31:0]         i_if_inst,
  output logic                o_re1,
  output logic                o_re2,
  output logic [REG_AW-1:0]   o_raddr1,
  output logic [REG_AW-1:0]   o_raddr2,
  input  logic [XLEN-1:0]     i_rdata1,
  input  logic [XLEN-1:0]     i_rdata2,
  input  logic                i_ex_we,
  input  logic                i_ex_is_load,
  input  logic [REG_AW-1:0]   i_ex_waddr,
  input  logic [XLEN-1:0]     i_ex_wdata,
  input  logic                i_mem_we,
  input  logic [REG_AW-1:0]   i_mem_waddr,
  input  logic [XLEN-1:0]     i_mem_wdata,
  input  logic                i_flush,
  output logic                o_id_valid,
  input  logic                i_ex_ready,
  output logic [ALUSEL_W-1:0] o_id_alusel,
  output logic [ALUOP_W-1:0]  o_id_aluop,
  output logic                o_id_we,
  output logic [REG_AW-1:0]   o_id_waddr,
  output logic [XLEN-1:0]     o_id_opv1,
  output logic [XLEN-1:0]     o_id_opv2,
  output logic [XLEN-1:0]     o_id_pc,
  output logic                o_id_illegal
);
  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP   = 3'b000;
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [ALUSEL_W-1:0] EXE_RES_ARITH = 3'b100;

  localparam logic [ALUOP_W-1:0] EXE_NOP_OP  = 8'h00;
  localparam logic [ALUOP_W-1:0] EXE_SRL_OP  = 8'h02;
  localparam logic [ALUOP_W-1:0] EXE_SRA_OP  = 8'h03;
  localparam logic [ALUOP_W-1:0] EXE_ADD_OP  = 8'h20;
  localparam logic [ALUOP_W-1:0] EXE_SUB_OP  = 8'h22;
  localparam logic [ALUOP_W-1:0] EXE_AND_OP  = 8'h24;
  localparam logic [ALUOP_W-1:0] EXE_OR_OP   = 8'h25;
  localparam logic [ALUOP_W-1:0] EXE_XOR_OP  = 8'h26;
  localparam logic [ALUOP_W-1:0] EXE_SLT_OP  = 8'h2a;
  localparam logic [ALUOP_W-1:0] EXE_SLTU_OP = 8'h2b;
  localparam logic [ALUOP_W-1:0] EXE_SLL_OP  = 8'h7c;

  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [1:0] SRC1_REG  = 2'd0;
  localparam logic [1:0] SRC1_ZERO = 2'd1;
  localparam logic [1:0] SRC1_PC   = 2'd2;

  logic [6:0] w_opc, w_f7, w_shhi, w_sra_hi;
  logic [2:0] w_f3;
  logic [REG_AW-1:0] w_rd;
  logic [XLEN-1:0] w_iimm, w_uimm, w_shamt;

  assign w_opc = i_if_inst[6:0];
  assign w_f3  = i_if_inst[14:12];
  assign w_f7  = i_if_inst[31:25];
  assign w_rd  = i_if_inst[11:7];
  assign w_iimm = {{(XLEN-12){i_if_inst[31]}}, i_if_inst[31:20]};
  assign w_uimm = {{(XLEN-31){i_if_inst[31]}}, i_if_inst[30:12], 12'b0};
  // RV64 shamt takes bit 25, leaving only inst[31:26] as the funct6 field.
  assign w_shamt  = (XLEN == 64) ? XLEN'(i_if_inst[25:20]) : XLEN'(i_if_inst[24:20]);
  assign w_shhi   = (XLEN == 64) ? {1'b0, i_if_inst[31:26]} : i_if_inst[31:25];
  assign w_sra_hi = (XLEN == 64) ? 7'h10 : 7'h20;

  logic w_illegal, w_re1, w_re2, w_use_imm, w_we;
  logic [1:0] w_src1;
  logic [ALUSEL_W-1:0] w_sel;
  logic [ALUOP_W-1:0] w_op;
  logic [XLEN-1:0] w_imm;

  always_comb begin
    w_illegal = 1'b1;
    w_re1     = 1'b0;
    w_re2     = 1'b0;
    w_use_imm = 1'b0;
    w_src1    = SRC1_ZERO;
    w_sel     = EXE_RES_NOP;
    w_op      = EXE_NOP_OP;
    w_imm     = '0;
    case (w_opc)
      OPC_OPIMM: begin
        w_illegal = 1'b0;
        w_re1     = 1'b1;
        w_use_imm = 1'b1;
        w_src1    = SRC1_REG;
        w_imm     = w_iimm;
        case (w_f3)
          3'b000: begin w_sel = EXE_RES_ARITH; w_op = EXE_ADD_OP;  end
          3'b010: begin w_sel = EXE_RES_ARITH; w_op = EXE_SLT_OP;  end
          3'b011: begin w_sel = EXE_RES_ARITH; w_op = EXE_SLTU_OP; end
          3'b100: begin w_sel = EXE_RES_LOGIC; w_op = EXE_XOR_OP;  end
          3'b110: begin w_sel = EXE_RES_LOGIC; w_op = EXE_OR_OP;   end
          3'b111: begin w_sel = EXE_RES_LOGIC; w_op = EXE_AND_OP;  end
          3'b001: begin
            w_sel = EXE_RES_SHIFT; w_op = EXE_SLL_OP; w_imm = w_shamt;
            w_illegal = (w_shhi != 7'h00);
          end
          default: begin
            w_sel = EXE_RES_SHIFT; w_imm = w_shamt;
            w_op  = (w_shhi == w_sra_hi) ? EXE_SRA_OP : EXE_SRL_OP;
            w_illegal = (w_shhi != 7'h00) && (w_shhi != w_sra_hi);
          end
        endcase
      end
      OPC_OP: begin
        w_re1  = 1'b1;
        w_re2  = 1'b1;
        w_src1 = SRC1_REG;
        w_illegal = !((w_f7 == 7'h00) ||
                      (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
        case (w_f3)
          3'b000: begin w_sel = EXE_RES_ARITH; w_op = w_f7[5] ? EXE_SUB_OP : EXE_ADD_OP; end
          3'b001: begin w_sel = EXE_RES_SHIFT; w_op = EXE_SLL_OP;  end
          3'b010: begin w_sel = EXE_RES_ARITH; w_op = EXE_SLT_OP;  end
          3'b011: begin w_sel = EXE_RES_ARITH; w_op = EXE_SLTU_OP; end
          3'b100: begin w_sel = EXE_RES_LOGIC; w_op = EXE_XOR_OP;  end
          3'b101: begin w_sel = EXE_RES_SHIFT; w_op = w_f7[5] ? EXE_SRA_OP : EXE_SRL_OP; end
          3'b110: begin w_sel = EXE_RES_LOGIC; w_op = EXE_OR_OP;   end
          default: begin w_sel = EXE_RES_LOGIC; w_op = EXE_AND_OP; end
        endcase
      end
      OPC_LUI, OPC_AUIPC: begin
        w_illegal = 1'b0;
        w_use_imm = 1'b1;
        w_src1    = (w_opc == OPC_AUIPC) ? SRC1_PC : SRC1_ZERO;
        w_imm     = w_uimm;
        w_sel     = EXE_RES_ARITH;
        w_op      = EXE_ADD_OP;
      end
      default: ;
    endcase
    if (w_illegal) begin
      w_re1     = 1'b0;
      w_re2     = 1'b0;
      w_use_imm = 1'b0;
      w_src1    = SRC1_ZERO;
      w_sel     = EXE_RES_NOP;
      w_op      = EXE_NOP_OP;
      w_imm     = '0;
    end
  end

  assign w_we = !w_illegal && (w_rd != '0);

  logic [1:0]             w_re, w_stall;
  logic [1:0][REG_AW-1:0] w_rs;
  logic [1:0][XLEN-1:0]   w_rdata, w_val;

  assign w_re    = {w_re2, w_re1};
  assign w_rs    = {i_if_inst[24:20], i_if_inst[19:15]};
  assign w_rdata = {i_rdata2, i_rdata1};

  for (genvar g = 0; g < 2; g++) begin : g_opnd
    id_opnd #(.XLEN(XLEN), .REG_AW(REG_AW)) u_opnd (
      .i_re        (w_re[g]),
      .i_rs        (w_rs[g]),
      .i_rdata     (w_rdata[g]),
      .i_ex_we     (i_ex_we),
      .i_ex_is_load(i_ex_is_load),
      .i_ex_waddr  (i_ex_waddr),
      .i_ex_wdata  (i_ex_wdata),
      .i_mem_we    (i_mem_we),
      .i_mem_waddr (i_mem_waddr),
      .i_mem_wdata (i_mem_wdata),
      .o_val       (w_val[g]),
      .o_stall     (w_stall[g])
    );
  end

  logic [XLEN-1:0] w_opv1, w_opv2;
  always_comb begin
    w_opv1 = '0;
    case (w_src1)
      SRC1_REG: w_opv1 = w_val[0];
      SRC1_PC:  w_opv1 = i_if_pc;
      default:  w_opv1 = '0;
    endcase
  end
  assign w_opv2 = w_use_imm ? w_imm : w_val[1];

  logic r_id_valid, w_stall_any, w_accept;
  assign w_stall_any = i_if_valid & (|w_stall);
  assign o_if_ready  = !w_stall_any & (!r_id_valid | i_ex_ready);
  assign w_accept    = i_if_valid & o_if_ready & !i_flush;

  assign o_re1    = w_re1;
  assign o_re2    = w_re2;
  assign o_raddr1 = w_rs[0];
  assign o_raddr2 = w_rs[1];

  logic [ALUSEL_W-1:0] r_alusel;
  logic [ALUOP_W-1:0]  r_aluop;
  logic                r_we, r_illegal;
  logic [REG_AW-1:0]   r_waddr;
  logic [XLEN-1:0]     r_opv1, r_opv2, r_pc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_id_valid <= 1'b0;
      r_alusel   <= '0;
      r_aluop    <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_opv1     <= '0;
      r_opv2     <= '0;
      r_pc       <= '0;
      r_illegal  <= 1'b0;
    end else if (i_flush) begin
      r_id_valid <= 1'b0;
      r_alusel   <= '0;
      r_aluop    <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_opv1     <= '0;
      r_opv2     <= '0;
      r_pc       <= '0;
      r_illegal  <= 1'b0;
    end else if (w_accept) begin
      r_id_valid <= 1'b1;
      r_alusel   <= w_sel;
      r_aluop    <= w_op;
      r_we       <= w_we;
      r_waddr    <= w_rd;
      r_opv1     <= w_opv1;
      r_opv2     <= w_opv2;
      r_pc       <= i_if_pc;
      r_illegal  <= w_illegal;
    end else if (i_ex_ready) begin
      // Drained or stalled: present a bubble, data left as-is.
      r_id_valid <= 1'b0;
    end
  end

  assign o_id_valid   = r_id_valid;
  assign o_id_alusel  = r_alusel;
  assign o_id_aluop   = r_aluop;
  assign o_id_we      = r_we;
  assign o_id_waddr   = r_waddr;
  assign o_id_opv1    = r_opv1;
  assign o_id_opv2    = r_opv2;
  assign o_id_pc      = r_pc;
  assign o_id_illegal = r_illegal;
endmodule
